// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and codes for the pipeline hazard controller.
package pipe_ctrl_pkg;
    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] TRAP_NONE   = 2'b00;
    localparam logic [1:0] TRAP_INVOP  = 2'b01;
    localparam logic [1:0] TRAP_INVMEM = 2'b10;
    localparam int DEF_DRAIN_INVOP  = 3;
    localparam int DEF_DRAIN_INVMEM = 1;
    localparam int DCNT_W = 8;
endpackage

// File: rtl/forwarding_unit.sv
// forwarding_unit: EX-stage operand forward selects; the younger EX/MEM result wins over MEM/WB.
module forwarding_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] i_rs1_ex,
    input  logic [REG_ADDR_W-1:0] i_rs2_ex,
    input  logic [REG_ADDR_W-1:0] i_rd_ex_mem,
    input  logic [REG_ADDR_W-1:0] i_rd_mem_wb,
    input  logic                  i_rw_ex_mem,
    input  logic                  i_rw_mem_wb,
    output logic [1:0]            o_forward_a,
    output logic [1:0]            o_forward_b
);
    logic w_exmem_ok, w_memwb_ok;
    assign w_exmem_ok  = i_rw_ex_mem && i_rd_ex_mem != '0;
    assign w_memwb_ok  = i_rw_mem_wb && i_rd_mem_wb != '0;
    assign o_forward_a = (w_exmem_ok && i_rd_ex_mem == i_rs1_ex) ? FWD_EXMEM :
                         (w_memwb_ok && i_rd_mem_wb == i_rs1_ex) ? FWD_MEMWB : FWD_RF;
    assign o_forward_b = (w_exmem_ok && i_rd_ex_mem == i_rs2_ex) ? FWD_EXMEM :
                         (w_memwb_ok && i_rd_mem_wb == i_rs2_ex) ? FWD_MEMWB : FWD_RF;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: forwarding, load-use stall, branch flush and drain-then-halt trap control.
// Optional PIPE_CTRL_PERF_CNT_EN adds saturating stall/flush/cycle counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W   = 5,
    parameter int DRAIN_INVOP  = DEF_DRAIN_INVOP,
    parameter int DRAIN_INVMEM = DEF_DRAIN_INVMEM
`ifdef PIPE_CTRL_PERF_CNT_EN
    , parameter int CNT_W      = 32
`endif
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [REG_ADDR_W-1:0] i_rs1,
    input  logic [REG_ADDR_W-1:0] i_rs2,
    input  logic                  i_uses_rs1,
    input  logic                  i_uses_rs2,
    input  logic [REG_ADDR_W-1:0] i_register_rs1_id_ex,
    input  logic [REG_ADDR_W-1:0] i_register_rs2_id_ex,
    input  logic [REG_ADDR_W-1:0] i_write_reg_id_ex,
    input  logic [REG_ADDR_W-1:0] i_write_reg_ex_mem,
    input  logic [REG_ADDR_W-1:0] i_write_reg_mem_wb,
    input  logic                  i_memread_id_ex,
    input  logic                  i_regwrite_ex_mem,
    input  logic                  i_regwrite_mem_wb,
    input  logic                  i_branch_ex_mem,
    input  logic                  i_zer0_ex_mem,
    input  logic                  i_inv_op,
    input  logic                  i_inv_mem_addr,
    output logic                  o_pc_write,
    output logic                  o_if_id_write,
    output logic                  o_if_id_flush,
    output logic                  o_id_ex_flush,
    output logic                  o_ex_mem_flush,
    output logic                  o_pc_src,
    output logic                  o_mem_kill,
    output logic [1:0]            o_forward_a,
    output logic [1:0]            o_forward_b,
    output logic                  o_halted,
    output logic [1:0]            o_trap_cause
`ifdef PIPE_CTRL_PERF_CNT_EN
    , output logic [CNT_W-1:0]    o_stall_cnt,
    output logic [CNT_W-1:0]      o_flush_cnt,
    output logic [CNT_W-1:0]      o_cycle_cnt
`endif
);
    state_t            r_state;
    logic [DCNT_W-1:0] r_cnt;
    logic [1:0]        r_cause;
    logic              w_taken, w_load_use, w_stall;
    logic [1:0]        w_fa, w_fb;

    forwarding_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd (
        .i_rs1_ex    (i_register_rs1_id_ex),
        .i_rs2_ex    (i_register_rs2_id_ex),
        .i_rd_ex_mem (i_write_reg_ex_mem),
        .i_rd_mem_wb (i_write_reg_mem_wb),
        .i_rw_ex_mem (i_regwrite_ex_mem),
        .i_rw_mem_wb (i_regwrite_mem_wb),
        .o_forward_a (w_fa),
        .o_forward_b (w_fb)
    );

    assign w_taken    = i_branch_ex_mem && i_zer0_ex_mem;
    assign w_load_use = i_memread_id_ex && i_write_reg_id_ex != '0 &&
                        ((i_uses_rs1 && i_rs1 == i_write_reg_id_ex) ||
                         (i_uses_rs2 && i_rs2 == i_write_reg_id_ex));
    assign w_stall    = r_state == RUN && !i_inv_mem_addr && !w_taken && !i_inv_op && w_load_use;

    // Reset gates every output so the datapath sees a frozen, bubble-free pipe while it is low.
    assign o_forward_a  = i_rst_n ? w_fa : FWD_RF;
    assign o_forward_b  = i_rst_n ? w_fb : FWD_RF;
    assign o_halted     = r_state == HALT;
    assign o_trap_cause = r_cause;

    always_comb begin
        o_pc_write     = 1'b0;
        o_if_id_write  = 1'b0;
        o_if_id_flush  = 1'b0;
        o_id_ex_flush  = 1'b0;
        o_ex_mem_flush = 1'b0;
        o_pc_src       = 1'b0;
        o_mem_kill     = 1'b0;
        if (i_rst_n) begin
            if (r_state == HALT) begin
                o_if_id_flush  = 1'b1;
                o_id_ex_flush  = 1'b1;
                o_ex_mem_flush = 1'b1;
                o_mem_kill     = 1'b1;
            end else if (r_state == DRAIN) begin
                o_if_id_write = 1'b1;
                o_if_id_flush = 1'b1;
                o_id_ex_flush = 1'b1;
            end else if (i_inv_mem_addr) begin
                o_if_id_write  = 1'b1;
                o_if_id_flush  = 1'b1;
                o_id_ex_flush  = 1'b1;
                o_ex_mem_flush = 1'b1;
                o_mem_kill     = 1'b1;
            end else if (w_taken) begin
                o_pc_write     = 1'b1;
                o_if_id_write  = 1'b1;
                o_pc_src       = 1'b1;
                o_if_id_flush  = 1'b1;
                o_id_ex_flush  = 1'b1;
                o_ex_mem_flush = 1'b1;
            end else if (i_inv_op) begin
                o_if_id_write = 1'b1;
                o_if_id_flush = 1'b1;
                o_id_ex_flush = 1'b1;
            end else if (w_load_use) begin
                o_id_ex_flush = 1'b1;
            end else begin
                o_pc_write    = 1'b1;
                o_if_id_write = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_cause <= TRAP_NONE;
        end else begin
            case (r_state)
                RUN: begin
                    if (i_inv_mem_addr) begin
                        r_state <= DRAIN;
                        r_cnt   <= DCNT_W'(DRAIN_INVMEM);
                        r_cause <= TRAP_INVMEM;
                    end else if (!w_taken && i_inv_op) begin
                        r_state <= DRAIN;
                        r_cnt   <= DCNT_W'(DRAIN_INVOP);
                        r_cause <= TRAP_INVOP;
                    end
                end
                DRAIN: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt <= DCNT_W'(1)) r_state <= HALT;
                end
                default: ;
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt, r_cycle_cnt;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_cycle_cnt <= '0;
        end else begin
            if (w_stall && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (r_state == RUN && !i_inv_mem_addr && w_taken && !(&r_flush_cnt))
                r_flush_cnt <= r_flush_cnt + 1'b1;
            if (r_state != HALT && !(&r_cycle_cnt)) r_cycle_cnt <= r_cycle_cnt + 1'b1;
        end
    end
    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;
    assign o_cycle_cnt = r_cycle_cnt;
`else
    logic w_unused;
    assign w_unused = w_stall;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed scenarios plus randomized run against a cycle-counting reference model.
module tb_pipeline_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1, rs2, rs1_ex, rs2_ex, wr_id_ex, wr_ex_mem, wr_mem_wb;
    logic       uses_rs1, uses_rs2, memread_id_ex, regwrite_ex_mem, regwrite_mem_wb;
    logic       branch_ex_mem, zer0_ex_mem, inv_op, inv_mem;
    logic       pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, pc_src, mem_kill, halted;
    logic [1:0] forward_a, forward_b, trap_cause;
`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt, cycle_cnt;
    int          m_stall, m_flush, m_cyc;
`endif
    int n_tests = 0;
    int n_fail  = 0;
    int m_cycle, m_trap, m_d;
    logic [1:0] m_cause;

    typedef struct packed {
        logic pc_write; logic if_id_write; logic if_id_flush; logic id_ex_flush;
        logic ex_mem_flush; logic pc_src; logic mem_kill;
        logic [1:0] fa; logic [1:0] fb; logic halted; logic [1:0] cause;
    } outs_t;
    outs_t dut_o;
    assign dut_o = {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, pc_src,
                    mem_kill, forward_a, forward_b, halted, trap_cause};

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rs1(rs1), .i_rs2(rs2),
        .i_uses_rs1(uses_rs1), .i_uses_rs2(uses_rs2),
        .i_register_rs1_id_ex(rs1_ex), .i_register_rs2_id_ex(rs2_ex),
        .i_write_reg_id_ex(wr_id_ex), .i_write_reg_ex_mem(wr_ex_mem), .i_write_reg_mem_wb(wr_mem_wb),
        .i_memread_id_ex(memread_id_ex), .i_regwrite_ex_mem(regwrite_ex_mem),
        .i_regwrite_mem_wb(regwrite_mem_wb), .i_branch_ex_mem(branch_ex_mem),
        .i_zer0_ex_mem(zer0_ex_mem), .i_inv_op(inv_op), .i_inv_mem_addr(inv_mem),
        .o_pc_write(pc_write), .o_if_id_write(if_id_write), .o_if_id_flush(if_id_flush),
        .o_id_ex_flush(id_ex_flush), .o_ex_mem_flush(ex_mem_flush), .o_pc_src(pc_src),
        .o_mem_kill(mem_kill), .o_forward_a(forward_a), .o_forward_b(forward_b),
        .o_halted(halted), .o_trap_cause(trap_cause)
`ifdef PIPE_CTRL_PERF_CNT_EN
        , .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt), .o_cycle_cnt(cycle_cnt)
`endif
    );

    task automatic idle();
        {rs1, rs2, rs1_ex, rs2_ex, wr_id_ex, wr_ex_mem, wr_mem_wb} = '0;
        {uses_rs1, uses_rs2, memread_id_ex, regwrite_ex_mem, regwrite_mem_wb} = '0;
        {branch_ex_mem, zer0_ex_mem, inv_op, inv_mem} = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        m_cycle = 0; m_trap = -1; m_d = 0; m_cause = 2'b00;
`ifdef PIPE_CTRL_PERF_CNT_EN
        m_stall = 0; m_flush = 0; m_cyc = 0;
`endif
    endtask

    function automatic logic [1:0] fwd(input logic [4:0] src);
        if (regwrite_ex_mem && wr_ex_mem != 0 && wr_ex_mem == src) return 2'b10;
        if (regwrite_mem_wb && wr_mem_wb != 0 && wr_mem_wb == src) return 2'b01;
        return 2'b00;
    endfunction

    // 0 running, 1 draining, 2 halted -- derived from how many edges have passed since the trap.
    function automatic int mode_now();
        if (m_trap < 0) return 0;
        return (m_cycle - m_trap <= m_d) ? 1 : 2;
    endfunction

    function automatic logic load_use();
        return memread_id_ex && wr_id_ex != 0 &&
               ((uses_rs1 && rs1 == wr_id_ex) || (uses_rs2 && rs2 == wr_id_ex));
    endfunction

    function automatic outs_t model_out();
        outs_t e = '0;
        int md = mode_now();
        logic tk = branch_ex_mem && zer0_ex_mem;
        e.fa = fwd(rs1_ex); e.fb = fwd(rs2_ex);
        e.halted = (md == 2); e.cause = m_cause;
        if (md == 2) {e.if_id_flush, e.id_ex_flush, e.ex_mem_flush, e.mem_kill} = '1;
        else if (md == 1) {e.if_id_flush, e.id_ex_flush} = '1;
        else if (inv_mem) {e.mem_kill, e.if_id_flush, e.id_ex_flush, e.ex_mem_flush} = '1;
        else if (tk) {e.pc_write, e.if_id_write, e.pc_src, e.if_id_flush, e.id_ex_flush, e.ex_mem_flush} = '1;
        else if (inv_op) {e.if_id_flush, e.id_ex_flush} = '1;
        else if (load_use()) e.id_ex_flush = 1'b1;
        else {e.pc_write, e.if_id_write} = '1;
        return e;
    endfunction

    task automatic test_reset();
        idle();
        regwrite_ex_mem = 1'b1; wr_ex_mem = 5'd3; rs1_ex = 5'd3; rs2_ex = 5'd3;
        rst_n = 1'b0;
        #2;
        n_tests++; if (dut_o !== '0) begin n_fail++; $display("FAIL reset_outputs got %h want 0", dut_o); end
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        #1;
        n_tests++; if (pc_write !== 1'b1 || if_id_write !== 1'b1) begin n_fail++; $display("FAIL reset_release_run got pc_write=%b if_id_write=%b want 1 1", pc_write, if_id_write); end
        n_tests++; if (halted !== 1'b0 || trap_cause !== 2'b00) begin n_fail++; $display("FAIL reset_release_trap got halted=%b cause=%b want 0 00", halted, trap_cause); end
        tick();
    endtask

    task automatic test_forwarding();
        idle();
        regwrite_ex_mem = 1'b1; wr_ex_mem = 5'd5; regwrite_mem_wb = 1'b1; wr_mem_wb = 5'd5;
        rs1_ex = 5'd5; rs2_ex = 5'd5;
        #1;
        n_tests++; if (forward_a !== 2'b10 || forward_b !== 2'b10) begin n_fail++; $display("FAIL fwd_exmem got %b %b want 10 10", forward_a, forward_b); end
        n_tests++; if (pc_write !== 1'b1) begin n_fail++; $display("FAIL fwd_nostall got pc_write=%b want 1", pc_write); end
        wr_ex_mem = 5'd0; wr_mem_wb = 5'd0; rs1_ex = 5'd0; rs2_ex = 5'd0;
        #1;
        n_tests++; if (forward_a !== 2'b00 || forward_b !== 2'b00) begin n_fail++; $display("FAIL fwd_x0 got %b %b want 00 00", forward_a, forward_b); end
        wr_ex_mem = 5'd9; wr_mem_wb = 5'd4; rs1_ex = 5'd4; rs2_ex = 5'd9;
        #1;
        n_tests++; if (forward_a !== 2'b01 || forward_b !== 2'b10) begin n_fail++; $display("FAIL fwd_mixed got %b %b want 01 10", forward_a, forward_b); end
        tick();
    endtask

    task automatic test_load_use();
        idle();
        memread_id_ex = 1'b1; wr_id_ex = 5'd5; rs1 = 5'd5; rs2 = 5'd7; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        #1;
        n_tests++; if ({pc_write, if_id_write, id_ex_flush} !== 3'b001) begin n_fail++; $display("FAIL lu_stall got %b want 001", {pc_write, if_id_write, id_ex_flush}); end
        tick();
        idle();
        rs1 = 5'd5; uses_rs1 = 1'b1; rs1_ex = 5'd5; rs2_ex = 5'd7;
        regwrite_mem_wb = 1'b1; wr_mem_wb = 5'd5;
        #1;
        n_tests++; if (forward_a !== 2'b01 || pc_write !== 1'b1) begin n_fail++; $display("FAIL lu_after got fa=%b pc_write=%b want 01 1", forward_a, pc_write); end
        tick();
        idle();
        memread_id_ex = 1'b1; wr_id_ex = 5'd0; rs1 = 5'd0; uses_rs1 = 1'b1;
        #1;
        n_tests++; if (pc_write !== 1'b1) begin n_fail++; $display("FAIL lu_x0 got pc_write=%b want 1", pc_write); end
        tick();
    endtask

    task automatic test_branch();
        idle();
        memread_id_ex = 1'b1; wr_id_ex = 5'd6; rs2 = 5'd6; uses_rs2 = 1'b1;
        branch_ex_mem = 1'b1; zer0_ex_mem = 1'b1;
        #1;
        n_tests++; if ({pc_src, if_id_flush, id_ex_flush, ex_mem_flush, pc_write} !== 5'b11111) begin n_fail++; $display("FAIL br_taken got %b want 11111", {pc_src, if_id_flush, id_ex_flush, ex_mem_flush, pc_write}); end
        tick();
        idle();
        branch_ex_mem = 1'b1;
        #1;
        n_tests++; if (pc_src !== 1'b0 || ex_mem_flush !== 1'b0) begin n_fail++; $display("FAIL br_not_taken got pc_src=%b ex_mem_flush=%b want 0 0", pc_src, ex_mem_flush); end
        tick();
    endtask

    task automatic test_invop();
        do_reset();
        idle();
        inv_op = 1'b1;
        #1;
        n_tests++; if ({pc_write, if_id_flush, id_ex_flush, ex_mem_flush} !== 4'b0110) begin n_fail++; $display("FAIL invop_entry got %b want 0110", {pc_write, if_id_flush, id_ex_flush, ex_mem_flush}); end
        tick();
        inv_op = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            #1;
            n_tests++; if (halted !== 1'b0 || pc_write !== 1'b0 || if_id_flush !== 1'b1) begin n_fail++; $display("FAIL invop_drain%0d got halted=%b pc_write=%b if_id_flush=%b want 0 0 1", k, halted, pc_write, if_id_flush); end
            tick();
        end
        #1;
        n_tests++; if (halted !== 1'b1 || trap_cause !== 2'b01) begin n_fail++; $display("FAIL invop_halt got halted=%b cause=%b want 1 01", halted, trap_cause); end
        n_tests++; if ({mem_kill, ex_mem_flush, if_id_write, pc_write} !== 4'b1100) begin n_fail++; $display("FAIL invop_halt_ctl got %b want 1100", {mem_kill, ex_mem_flush, if_id_write, pc_write}); end
        inv_mem = 1'b1;
        tick();
        inv_mem = 1'b0;
        #1;
        n_tests++; if (halted !== 1'b1 || trap_cause !== 2'b01) begin n_fail++; $display("FAIL invop_sticky got halted=%b cause=%b want 1 01", halted, trap_cause); end
        tick();
    endtask

    task automatic test_invmem();
        do_reset();
        idle();
        inv_mem = 1'b1; inv_op = 1'b1;
        #1;
        n_tests++; if ({mem_kill, pc_write, ex_mem_flush} !== 3'b101) begin n_fail++; $display("FAIL invmem_entry got %b want 101", {mem_kill, pc_write, ex_mem_flush}); end
        tick();
        idle();
        #1;
        n_tests++; if (halted !== 1'b0 || mem_kill !== 1'b0) begin n_fail++; $display("FAIL invmem_drain got halted=%b mem_kill=%b want 0 0", halted, mem_kill); end
        tick();
        #1;
        n_tests++; if (halted !== 1'b1 || trap_cause !== 2'b10) begin n_fail++; $display("FAIL invmem_halt got halted=%b cause=%b want 1 10", halted, trap_cause); end
        do_reset();
        inv_mem = 1'b1;
        tick();
        idle();
        rst_n = 1'b0;
        #1;
        n_tests++; if (dut_o !== '0) begin n_fail++; $display("FAIL reset_mid_drain got %h want 0", dut_o); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        #1;
        n_tests++; if (halted !== 1'b0 || trap_cause !== 2'b00 || pc_write !== 1'b1) begin n_fail++; $display("FAIL reset_drain_exit got halted=%b cause=%b pc_write=%b want 0 00 1", halted, trap_cause, pc_write); end
        tick();
    endtask

`ifdef PIPE_CTRL_PERF_CNT_EN
    task automatic test_perf();
        do_reset();
        idle();
        #1;
        n_tests++; if (stall_cnt !== 0 || flush_cnt !== 0) begin n_fail++; $display("FAIL perf_reset got %0d %0d want 0 0", stall_cnt, flush_cnt); end
        memread_id_ex = 1'b1; wr_id_ex = 5'd5; rs1 = 5'd5; uses_rs1 = 1'b1;
        tick();
        idle();
        tick();
        memread_id_ex = 1'b1; wr_id_ex = 5'd2; rs2 = 5'd2; uses_rs2 = 1'b1;
        tick();
        idle();
        branch_ex_mem = 1'b1; zer0_ex_mem = 1'b1;
        tick();
        idle();
        tick();
        #1;
        n_tests++; if (stall_cnt !== 2 || flush_cnt !== 1 || cycle_cnt !== 5) begin n_fail++; $display("FAIL perf_counts got %0d %0d %0d want 2 1 5", stall_cnt, flush_cnt, cycle_cnt); end
    endtask
`endif

    task automatic test_random();
        outs_t e, m, d;
        int md;
        logic tk;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            {rs1, rs2, rs1_ex, rs2_ex} = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            {wr_id_ex, wr_ex_mem, wr_mem_wb} = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                                                5'($urandom_range(0, 3))};
            {uses_rs1, uses_rs2, memread_id_ex, regwrite_ex_mem, regwrite_mem_wb} = 5'($urandom);
            branch_ex_mem = 1'($urandom); zer0_ex_mem = ($urandom_range(0, 3) == 0);
            inv_op = ($urandom_range(0, 39) == 0); inv_mem = ($urandom_range(0, 59) == 0);
            #1;
            e = model_out();
            m = '1;
            if (e.if_id_flush) m.if_id_write = 1'b0;
            d = dut_o & m;
            n_tests++; if (d !== (e & m)) begin n_fail++; $display("FAIL rand_cycle%0d got %h want %h", i, d, e & m); end
            md = mode_now();
            tk = branch_ex_mem && zer0_ex_mem;
`ifdef PIPE_CTRL_PERF_CNT_EN
            if (md == 0 && !inv_mem && !tk && !inv_op && load_use()) m_stall++;
            if (md == 0 && !inv_mem && tk) m_flush++;
            if (md != 2) m_cyc++;
`endif
            if (md == 0 && inv_mem) begin m_trap = m_cycle; m_d = 1; m_cause = 2'b10; end
            else if (md == 0 && !tk && inv_op) begin m_trap = m_cycle; m_d = 3; m_cause = 2'b01; end
            m_cycle++;
            tick();
`ifdef PIPE_CTRL_PERF_CNT_EN
            #1;
            n_tests++; if (stall_cnt !== 32'(m_stall) || flush_cnt !== 32'(m_flush) || cycle_cnt !== 32'(m_cyc)) begin n_fail++; $display("FAIL rand_perf%0d got %0d %0d %0d want %0d %0d %0d", i, stall_cnt, flush_cnt, cycle_cnt, m_stall, m_flush, m_cyc); end
`endif
            if ((mode_now() == 2 && $urandom_range(0, 5) == 0) || $urandom_range(0, 299) == 0) do_reset();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        m_cycle = 0; m_trap = -1; m_d = 0; m_cause = 2'b00;
        @(negedge clk);
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_invop();
        test_invmem();
`ifdef PIPE_CTRL_PERF_CNT_EN
        test_perf();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
